// File: rtl/link_2p.sv
`timescale 1ns/1ps
// link_2p: player-2 end of the inter-board GPIO link. Synchronizes and
// debounces OK/NUM/JUDG, runs the READY/OK handshake to receive the
// question index, returns the local result and holds it until judged.
// Optional feature macro: LINK_TIMEOUT_EN (wait-state timeout abort).
// Ports:
//   CLK, RST           clock, async active-low reset
//   OK/NUM/JUDG_in_GPIO  async inputs from player 1
//   READY/RESULT/CHAR_NUM_LOCAL  local control/check inputs
//   READY/RESULT/CHAR_NUM_out_GPIO  registered outputs to player 1
//   NUM, NUM_VALID, JUDG, JUDG_VALID  captured values + strobes
//   STATE, TIMEOUT     debug state code, timeout strobe
module link_2p #(
   parameter int STABLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       OK_in_GPIO,
   input  logic [3:0] NUM_in_GPIO,
   input  logic [1:0] JUDG_in_GPIO,
   input  logic       READY_LOCAL,
   input  logic [1:0] RESULT_LOCAL,
   input  logic [2:0] CHAR_NUM_LOCAL,
   output logic       READY_out_GPIO,
   output logic [1:0] RESULT_out_GPIO,
   output logic [2:0] CHAR_NUM_out_GPIO,
   output logic [3:0] NUM,
   output logic       NUM_VALID,
   output logic [1:0] JUDG,
   output logic       JUDG_VALID,
   output logic [2:0] STATE,
   output logic       TIMEOUT
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_OK   = 3'd1,
      S_CAPTURE   = 3'd2,
      S_WAIT_OKLO = 3'd3,
      S_PLAY      = 3'd4,
      S_WAIT_JUDG = 3'd5,
      S_RELEASE   = 3'd6
   } state_t;

   localparam logic [3:0] STB = 4'(STABLE_CYC);

   state_t     state_q, state_d;
   logic       ok_s1, ok_s2;
   logic [3:0] num_s1, num_s2;
   logic [1:0] judg_s1, judg_s2;
   logic [3:0] ok_cnt, num_cnt, judg_cnt;
   logic       ok_hi, ok_lo, num_ok, judg_ok;

   logic       ready_q, ready_d;
   logic [1:0] result_q, result_d;
   logic [3:0] num_q, num_d;
   logic       nv_q, nv_d;
   logic [1:0] judg_q, judg_d;
   logic       jv_q, jv_d;
   logic       tmo_q, tmo_d;
   logic [2:0] char_q;
   logic       tmo_hit;

   // Counters restart on the same edge the synchronized value changes
   // (stage 1 differs from stage 2), then saturate at STB.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ok_s1    <= 1'b0;
         ok_s2    <= 1'b0;
         num_s1   <= 4'd0;
         num_s2   <= 4'd0;
         judg_s1  <= 2'd0;
         judg_s2  <= 2'd0;
         ok_cnt   <= 4'd0;
         num_cnt  <= 4'd0;
         judg_cnt <= 4'd0;
      end else begin
         ok_s1   <= OK_in_GPIO;
         ok_s2   <= ok_s1;
         num_s1  <= NUM_in_GPIO;
         num_s2  <= num_s1;
         judg_s1 <= JUDG_in_GPIO;
         judg_s2 <= judg_s1;
         if (ok_s1 != ok_s2)
            ok_cnt <= 4'd0;
         else if (ok_cnt != STB)
            ok_cnt <= ok_cnt + 4'd1;
         if (num_s1 != num_s2)
            num_cnt <= 4'd0;
         else if (num_cnt != STB)
            num_cnt <= num_cnt + 4'd1;
         if (judg_s1 != judg_s2)
            judg_cnt <= 4'd0;
         else if (judg_cnt != STB)
            judg_cnt <= judg_cnt + 4'd1;
      end
   end

   assign ok_hi   = (ok_cnt == STB) && ok_s2;
   assign ok_lo   = (ok_cnt == STB) && !ok_s2;
   assign num_ok  = (num_cnt == STB);
   assign judg_ok = (judg_cnt == STB);

`ifdef LINK_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] tmo_cnt;
   logic          waiting;

   assign waiting = (state_q == S_WAIT_OK)   ||
                    (state_q == S_WAIT_OKLO) ||
                    (state_q == S_WAIT_JUDG) ||
                    (state_q == S_RELEASE);
   assign tmo_hit = waiting && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         tmo_cnt <= '0;
      else if (!waiting || (state_d != state_q))
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + TW'(1);
   end
`else
   logic unused_tmo;
   assign unused_tmo = ^TIMEOUT_CYC;
   assign tmo_hit    = 1'b0;
`endif

   // Outputs are computed one state ahead and registered, so every
   // GPIO-facing signal is a flop output.
   always_comb begin
      state_d  = state_q;
      ready_d  = ready_q;
      result_d = result_q;
      num_d    = num_q;
      nv_d     = 1'b0;
      judg_d   = judg_q;
      jv_d     = 1'b0;
      tmo_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            ready_d  = 1'b0;
            result_d = 2'd0;
            if (READY_LOCAL) begin
               state_d = S_WAIT_OK;
               ready_d = 1'b1;
            end
         end
         S_WAIT_OK: begin
            if (ok_hi && num_ok) begin
               state_d = S_CAPTURE;
               num_d   = num_s2;
               nv_d    = 1'b1;
            end
         end
         S_CAPTURE: begin
            ready_d = 1'b0;
            state_d = S_WAIT_OKLO;
         end
         S_WAIT_OKLO: begin
            if (ok_lo)
               state_d = S_PLAY;
         end
         S_PLAY: begin
            if ((RESULT_LOCAL == 2'b01) || (RESULT_LOCAL == 2'b10)) begin
               result_d = RESULT_LOCAL;
               state_d  = S_WAIT_JUDG;
            end
         end
         S_WAIT_JUDG: begin
            if (judg_ok && (judg_s2 != 2'd0)) begin
               judg_d  = judg_s2;
               jv_d    = 1'b1;
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            result_d = 2'd0;
            if (judg_ok && (judg_s2 == 2'd0))
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (tmo_hit) begin
         state_d  = S_IDLE;
         ready_d  = 1'b0;
         result_d = 2'd0;
         num_d    = num_q;
         nv_d     = 1'b0;
         judg_d   = judg_q;
         jv_d     = 1'b0;
         tmo_d    = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= S_IDLE;
         ready_q  <= 1'b0;
         result_q <= 2'd0;
         num_q    <= 4'd0;
         nv_q     <= 1'b0;
         judg_q   <= 2'd0;
         jv_q     <= 1'b0;
         tmo_q    <= 1'b0;
         char_q   <= 3'd0;
      end else begin
         state_q  <= state_d;
         ready_q  <= ready_d;
         result_q <= result_d;
         num_q    <= num_d;
         nv_q     <= nv_d;
         judg_q   <= judg_d;
         jv_q     <= jv_d;
         tmo_q    <= tmo_d;
         char_q   <= CHAR_NUM_LOCAL;
      end
   end

   assign READY_out_GPIO    = ready_q;
   assign RESULT_out_GPIO   = result_q;
   assign CHAR_NUM_out_GPIO = char_q;
   assign NUM               = num_q;
   assign NUM_VALID         = nv_q;
   assign JUDG              = judg_q;
   assign JUDG_VALID        = jv_q;
   assign STATE             = state_q;
   assign TIMEOUT           = tmo_q;

endmodule
